// File: rtl/turf_event_fragmenter.sv
// -----------------------------------------------------------------------------
// turf_event_fragmenter
//
// Cuts a 64-bit event stream (one event per tlast-terminated packet) into UDP
// fragments of at most nfragment_count_i+1 data qwords. Each fragment is fully
// buffered first so the UDP length is exact. It is then emitted as one UDP
// header beat, one fragment-header qword, and the buffered data qwords.
//
// Ports
//   aclk, aresetn          clock, synchronous active-low reset
//   s_evdata_*             event data input (AXI4-S, tkeep ignored)
//   nfragment_count_i      data qwords per fragment minus 1
//   event_ip_i/port_i      destination, latched at event start
//   event_open_i           event path open
//   m_udphdr_*             {ip, port, length_bytes} header stream
//   m_udpdata_*            fragment header + payload stream
//   event_count_o          events fully sent (also the next event number)
//   drop_count_o           events discarded on a closed path, saturating
//
// Optional feature: define TURF_FRAG_HOLD_EN to stall a closed path in IDLE
// instead of discarding the event. drop_count_o then stays 0.
// -----------------------------------------------------------------------------
module turf_event_fragmenter #(
  parameter int BUF_ADDR_BITS = 10,
  parameter int EVNUM_BITS    = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [63:0]           s_evdata_tdata,
  input  logic [7:0]            s_evdata_tkeep,
  input  logic                  s_evdata_tlast,
  input  logic                  s_evdata_tvalid,
  output logic                  s_evdata_tready,
  input  logic [9:0]            nfragment_count_i,
  input  logic [31:0]           event_ip_i,
  input  logic [15:0]           event_port_i,
  input  logic                  event_open_i,
  output logic [63:0]           m_udphdr_tdata,
  output logic                  m_udphdr_tvalid,
  input  logic                  m_udphdr_tready,
  output logic [63:0]           m_udpdata_tdata,
  output logic [7:0]            m_udpdata_tkeep,
  output logic                  m_udpdata_tlast,
  output logic                  m_udpdata_tvalid,
  input  logic                  m_udpdata_tready,
  output logic [EVNUM_BITS-1:0] event_count_o,
  output logic [15:0]           drop_count_o
);

  localparam int WC_W = BUF_ADDR_BITS + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_HDR, S_FHDR, S_DRAIN, S_DISCARD
  } state_t;

  state_t                  state_q, state_d;
  logic [9:0]              nfrag_q, nfrag_d;
  logic [31:0]             ip_q, ip_d;
  logic [15:0]             port_q, port_d;
  logic [WC_W-1:0]         wcnt_q, wcnt_d;
  logic [WC_W-1:0]         rptr_q, rptr_d;
  logic                    last_q, last_d;
  logic [15:0]             fidx_q, fidx_d;
  logic [EVNUM_BITS-1:0]   evnum_q, evnum_d;
  logic [15:0]             drop_q, drop_d;

  logic [63:0]             buf_mem [0:(1 << BUF_ADDR_BITS)-1];
  logic [63:0]             rd_data_q;
  logic [BUF_ADDR_BITS-1:0] rd_addr;
  logic                    wr_en;
  logic                    drain_final;

  logic unused_tkeep;
  assign unused_tkeep = ^s_evdata_tkeep;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // rptr_q indexes the qword currently on m_udpdata; it is only non-zero in DRAIN
  assign drain_final = (rptr_q == wcnt_q - WC_W'(1));

  // Read one ahead on a DRAIN handshake so the registered read port never bubbles
  always_comb begin
    if (state_q == S_DRAIN && m_udpdata_tready)
      rd_addr = BUF_ADDR_BITS'(rptr_q + WC_W'(1));
    else
      rd_addr = BUF_ADDR_BITS'(rptr_q);
  end

  assign wr_en = (state_q == S_FILL) && s_evdata_tvalid;

  always_ff @(posedge aclk) begin
    if (wr_en) buf_mem[wcnt_q[BUF_ADDR_BITS-1:0]] <= s_evdata_tdata;
    rd_data_q <= buf_mem[rd_addr];
  end

  // State register
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      rptr_q  <= '0;
      last_q  <= 1'b0;
      fidx_q  <= '0;
      evnum_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rptr_q  <= rptr_d;
      last_q  <= last_d;
      fidx_q  <= fidx_d;
      evnum_q <= evnum_d;
      drop_q  <= drop_d;
    end
  end

  // Event config only matters between IDLE and the end of the event
  always_ff @(posedge aclk) begin
    nfrag_q <= nfrag_d;
    ip_q    <= ip_d;
    port_q  <= port_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    nfrag_d = nfrag_q;
    ip_d    = ip_q;
    port_d  = port_q;
    wcnt_d  = wcnt_q;
    rptr_d  = rptr_q;
    last_d  = last_q;
    fidx_d  = fidx_q;
    evnum_d = evnum_q;
    drop_d  = drop_q;
    case (state_q)
      S_IDLE: begin
        if (s_evdata_tvalid) begin
          if (event_open_i) begin
            nfrag_d = nfragment_count_i;
            ip_d    = event_ip_i;
            port_d  = event_port_i;
            fidx_d  = '0;
            wcnt_d  = '0;
            state_d = S_FILL;
          end else begin
`ifdef TURF_FRAG_HOLD_EN
            state_d = S_IDLE;
`else
            state_d = S_DISCARD;
`endif
          end
        end
      end
      S_FILL: begin
        if (s_evdata_tvalid) begin
          wcnt_d = wcnt_q + WC_W'(1);
          // tlast wins when it coincides with a full buffer: no empty trailer
          if (s_evdata_tlast || wcnt_q == WC_W'(nfrag_q)) begin
            last_d  = s_evdata_tlast;
            state_d = S_HDR;
          end
        end
      end
      S_HDR: begin
        if (m_udphdr_tready) state_d = S_FHDR;
      end
      S_FHDR: begin
        if (m_udpdata_tready) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (m_udpdata_tready) begin
          rptr_d = rptr_q + WC_W'(1);
          if (drain_final) begin
            rptr_d = '0;
            if (last_q) begin
              evnum_d = evnum_q + EVNUM_BITS'(1);
              state_d = S_IDLE;
            end else begin
              fidx_d  = fidx_q + 16'd1;
              wcnt_d  = '0;
              state_d = S_FILL;
            end
          end
        end
      end
      S_DISCARD: begin
        if (s_evdata_tvalid && s_evdata_tlast) begin
          drop_d  = sat_inc16(drop_q);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    s_evdata_tready  = 1'b0;
    m_udphdr_tvalid  = 1'b0;
    m_udpdata_tvalid = 1'b0;
    m_udpdata_tlast  = 1'b0;
    m_udpdata_tdata  = rd_data_q;
    case (state_q)
      S_FILL, S_DISCARD: s_evdata_tready = 1'b1;
      S_HDR:             m_udphdr_tvalid = 1'b1;
      S_FHDR: begin
        m_udpdata_tvalid = 1'b1;
        m_udpdata_tdata  = {32'(evnum_q), fidx_q, last_q, 15'(wcnt_q)};
      end
      S_DRAIN: begin
        m_udpdata_tvalid = 1'b1;
        m_udpdata_tlast  = drain_final;
      end
      default: ;
    endcase
  end

  // Length counts the fragment-header qword plus the data qwords
  assign m_udphdr_tdata  = {ip_q, port_q, 16'({wcnt_q + WC_W'(1), 3'b000})};
  assign m_udpdata_tkeep = 8'hFF;
  assign event_count_o   = evnum_q;
  assign drop_count_o    = drop_q;

endmodule
